traffic_sequencer: RTL and testbench

TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

---
 rtl/traffic_sequencer.sv | 132 +++++++++++++
 tb/tb_traffic_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sequencer.sv
// Two-direction traffic light sequencer with an optional pedestrian walk phase.
// Phase lengths are counted in tick_en pulses; all outputs are registered.
module traffic_sequencer #(
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       enable,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       cycle_tick,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_e;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TICKS - 1);
    localparam logic [7:0] WALK_LAST   = 8'(WALK_TICKS - 1);

    state_e     state_q, state_d, next_state;
    logic [7:0] timer_q, timer_d, phase_last;
    logic       ped_pending_q, ped_pending_d;
    logic [2:0] ns_light_q, ns_light_d;
    logic [2:0] ew_light_q, ew_light_d;
    logic       walk_q, walk_d;
    logic       cycle_tick_q, cycle_tick_d;
    logic       illegal;

    always_comb begin
        phase_last = GREEN_LAST;
        next_state = NS_GREEN;
        case (state_q)
            NS_GREEN:  begin phase_last = GREEN_LAST;  next_state = NS_YELLOW; end
            NS_YELLOW: begin phase_last = YELLOW_LAST; next_state = ALLRED_A;  end
            ALLRED_A:  begin phase_last = ALLRED_LAST; next_state = EW_GREEN;  end
            EW_GREEN:  begin phase_last = GREEN_LAST;  next_state = EW_YELLOW; end
            EW_YELLOW: begin phase_last = YELLOW_LAST; next_state = ALLRED_B;  end
            ALLRED_B:  begin
                phase_last = ALLRED_LAST;
                next_state = ped_pending_q ? PED_WALK : NS_GREEN;
            end
            PED_WALK:  begin phase_last = WALK_LAST;   next_state = NS_GREEN;  end
            default:   begin phase_last = GREEN_LAST;  next_state = NS_GREEN;  end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cycle_tick_d = 1'b0;
        illegal      = (state_q == 3'd7);

        // Encoding 7 recovers unconditionally and is not a completed cycle.
        if (illegal) begin
            state_d = NS_GREEN;
            timer_d = '0;
        end else if (enable && tick_en) begin
            if (timer_q == phase_last) begin
                timer_d      = '0;
                state_d      = next_state;
                cycle_tick_d = (next_state == NS_GREEN) &&
                               ((state_q == ALLRED_B) || (state_q == PED_WALK));
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end

        // A request on the same clock that enters PED_WALK stays pending.
        ped_pending_d = ped_req |
                        (ped_pending_q & ~((state_d == PED_WALK) && (state_q != PED_WALK)));

        // Lights decode from the next state so they change on the transition edge.
        ns_light_d = LIGHT_RED;
        ew_light_d = LIGHT_RED;
        walk_d     = 1'b0;
        case (state_d)
            NS_GREEN:  ns_light_d = LIGHT_GREEN;
            NS_YELLOW: ns_light_d = LIGHT_YELLOW;
            EW_GREEN:  ew_light_d = LIGHT_GREEN;
            EW_YELLOW: ew_light_d = LIGHT_YELLOW;
            PED_WALK:  walk_d     = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NS_GREEN;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
            ns_light_q    <= LIGHT_GREEN;
            ew_light_q    <= LIGHT_RED;
            walk_q        <= 1'b0;
            cycle_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            ns_light_q    <= ns_light_d;
            ew_light_q    <= ew_light_d;
            walk_q        <= walk_d;
            cycle_tick_q  <= cycle_tick_d;
        end
    end

    assign ns_light   = ns_light_q;
    assign ew_light   = ew_light_q;
    assign walk       = walk_q;
    assign cycle_tick = cycle_tick_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer: phase-table model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_traffic_sequencer;

    localparam int G = 4;
    localparam int Y = 2;
    localparam int A = 1;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b1;
    logic       enable = 1'b1;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light, ew_light, state_out;
    logic       walk, cycle_tick;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    traffic_sequencer #(
        .GREEN_TICKS (G),
        .YELLOW_TICKS(Y),
        .ALLRED_TICKS(A),
        .WALK_TICKS  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en),
        .enable    (enable),
        .ped_req   (ped_req),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .walk      (walk),
        .cycle_tick(cycle_tick),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // Model: phase index into a duration table, ticks elapsed in that phase.
    int dur[7] = '{G, Y, A, G, Y, A, W};
    int m_state = 0;
    int m_cnt = 0;
    bit m_pend = 1'b0;
    bit m_ct = 1'b0;

    always @(posedge clk) begin : model
        bit enter_walk;
        enter_walk = 1'b0;
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
            m_ct    = 1'b0;
        end else begin
            m_ct = 1'b0;
            if (enable && tick_en) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == dur[m_state]) begin
                    m_cnt = 0;
                    if (m_state == 5 && m_pend) begin
                        m_state    = 6;
                        enter_walk = 1'b1;
                    end else if (m_state >= 5) begin
                        m_state = 0;
                        m_ct    = 1'b1;
                    end else begin
                        m_state = m_state + 1;
                    end
                end
            end
            m_pend = ped_req || (m_pend && !enter_walk);
        end
    end

    function automatic logic [2:0] exp_ns(input int s);
        return (s == 0) ? 3'b001 : (s == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] exp_ew(input int s);
        return (s == 3) ? 3'b001 : (s == 4) ? 3'b010 : 3'b100;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (state_out !== 3'(m_state) || ns_light !== exp_ns(m_state) ||
                ew_light !== exp_ew(m_state) || walk !== (m_state == 6) ||
                cycle_tick !== m_ct) begin
                errors++;
                $display("FAIL model_cmp t=%0t state=%0d/%0d ns=%b/%b ew=%b/%b walk=%b/%b ct=%b/%b",
                         $time, state_out, m_state, ns_light, exp_ns(m_state),
                         ew_light, exp_ew(m_state), walk, (m_state == 6), cycle_tick, m_ct);
            end
            checks++;
            if (!$onehot(ns_light) || !$onehot(ew_light) ||
                (ns_light !== 3'b100 && ew_light !== 3'b100)) begin
                errors++;
                $display("FAIL safety t=%0t ns=%b ew=%b (need one-hot, at least one red)",
                         $time, ns_light, ew_light);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (state_out !== 3'(s) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state_out), 32'(s));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int exp_seq[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5};

    initial begin : stim
        int n;
        bit saw6;
        logic [2:0] snap_ns, snap_ew;

        // Full cycle from reset, tick_en high throughout (also during reset).
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("rst_ns", 32'(ns_light), 32'(3'b001));
                check("rst_ew", 32'(ew_light), 32'(3'b100));
                check("rst_walk", 32'(walk), 0);
                check("rst_ct", 32'(cycle_tick), 0);
            end
            if (i < 14) check("seq_first", 32'(state_out), 32'(exp_seq[i]));
            else if (i < 28) check("seq_second", 32'(state_out), 32'(exp_seq[i - 14]));
            if (i == 13 || i == 27) check("ct_before", 32'(cycle_tick), 0);
            if (i == 14 || i == 28) check("ct_pulse", 32'(cycle_tick), 1);
        end

        // Pedestrian request pulse during EW_GREEN.
        wait_state(3, 30, "reach_ew_green");
        @(posedge clk); #1; ped_req = 1'b1;
        @(posedge clk); #1; ped_req = 1'b0;
        @(negedge clk);
        wait_state(6, 30, "reach_walk");
        n = 0;
        while (walk === 1'b1 && n < 10) begin
            n++;
            check("walk_lights", 32'({ns_light, ew_light}), 32'(6'b100100));
            @(negedge clk);
        end
        check("walk_len", 32'(n), 3);
        check("after_walk_state", 32'(state_out), 0);
        check("after_walk_ct", 32'(cycle_tick), 1);
        saw6 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_out == 3'd6) saw6 = 1'b1;
        end
        check("no_second_walk", 32'(saw6), 0);

        // Freeze mid NS_YELLOW for 5 clocks; ped_req still latches.
        wait_state(1, 30, "reach_ns_yellow");
        @(posedge clk); #1; enable = 1'b0;
        snap_ns = ns_light;
        snap_ew = ew_light;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frz_state", 32'(state_out), 1);
            check("frz_lights", 32'({ns_light, ew_light}), 32'({snap_ns, snap_ew}));
            check("frz_ct", 32'(cycle_tick), 0);
            if (i == 1) ped_req = 1'b1;
            if (i == 2) ped_req = 1'b0;
        end
        enable = 1'b1;
        @(negedge clk);
        check("frz_resume", 32'(state_out), 2);
        wait_state(6, 40, "frz_ped_latched");

        // Sparse tick (every 4th clock), tick_en high while in reset.
        @(posedge clk); #1;
        rst = 1'b1; tick_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick_en = (k % 4 == 3);
            @(negedge clk);
            if (state_out == 3'd0) n++;
            else break;
            @(posedge clk); #1;
        end
        check("sparse_green_len", 32'(n), 32'(4 * G));
        tick_en = 1'b1;

        // Reset in EW_GREEN with a pending request.
        @(negedge clk);
        wait_state(3, 40, "reach_ew_green2");
        @(posedge clk); #1; ped_req = 1'b1;
        @(posedge clk); #1; ped_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(state_out), 0);
        check("midrst_ns", 32'(ns_light), 32'(3'b001));
        check("midrst_ct", 32'(cycle_tick), 0);
        saw6 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_out == 3'd6) saw6 = 1'b1;
        end
        check("midrst_no_walk", 32'(saw6), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
